// File: rtl/iod_delay_line_step_ctrl_if.sv
// iod_delay_line_step_ctrl_if: command/completion handshake between lane training logic and the step controller
interface iod_delay_line_step_ctrl_if #(parameter int STEP_W = 8);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic              cmd_dir;
  logic [STEP_W-1:0] cmd_steps;
  logic              done;
  logic              done_oor;
  logic [STEP_W-1:0] steps_done;
  modport master (output cmd_valid, cmd_op, cmd_dir, cmd_steps, input cmd_ready, done, done_oor, steps_done);
  modport slave  (input cmd_valid, cmd_op, cmd_dir, cmd_steps, output cmd_ready, done, done_oor, steps_done);
endinterface

// File: rtl/iod_delay_line_step_ctrl.sv
// iod_delay_line_step_ctrl: sequences MOVE/LOAD pulses for one IOD delay line and tracks the tap; DLY_CTRL_TAP_CLAMP_EN enables the tap clamp
module iod_delay_line_step_ctrl #(
  parameter int STEP_W        = 8,
  parameter int TAP_W         = 8,
  parameter int TAP_RESET_VAL = 1,
  parameter int TAP_MAX       = 127,
  parameter int GAP_CYCLES    = 3,
  parameter int LOAD_CYCLES   = 2
) (
  input  logic                       fab_clk,
  input  logic                       sync_rst,
  iod_delay_line_step_ctrl_if.slave  cmd,
  output logic [TAP_W-1:0]           tap_pos,
  output logic                       delay_line_move_0,
  output logic                       delay_line_direction_0,
  output logic                       delay_line_load_0,
  input  logic                       delay_line_out_of_range_0
);
  localparam int CNT_MAX = GAP_CYCLES > LOAD_CYCLES ? GAP_CYCLES : LOAD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
`ifdef DLY_CTRL_TAP_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MOVE, S_GAP, S_DONE} state_t;
  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [STEP_W-1:0]  steps_q;
  logic [STEP_W-1:0]  steps_nxt;
  logic [TAP_W-1:0]   tap_nxt;
  logic               clamp_now;
  logic               clamp_nxt;
  // clamp_now guards the first pulse, clamp_nxt every later pulse (against the post-step tap)
  always_comb begin
    steps_nxt = cmd.steps_done + 1'b1;
    tap_nxt   = delay_line_direction_0 ? tap_pos + 1'b1 : tap_pos - 1'b1;
    clamp_now = CLAMP && (cmd.cmd_dir ? tap_pos == TAP_W'(TAP_MAX) : tap_pos == '0);
    clamp_nxt = CLAMP && (delay_line_direction_0 ? tap_nxt == TAP_W'(TAP_MAX) : tap_nxt == '0);
  end
  always_ff @(posedge fab_clk) begin
    if (sync_rst) begin
      state                  <= S_IDLE;
      cnt                    <= '0;
      steps_q                <= '0;
      tap_pos                <= TAP_W'(TAP_RESET_VAL);
      delay_line_move_0      <= 1'b0;
      delay_line_direction_0 <= 1'b0;
      delay_line_load_0      <= 1'b0;
      cmd.cmd_ready          <= 1'b0;
      cmd.done               <= 1'b0;
      cmd.done_oor           <= 1'b0;
      cmd.steps_done         <= '0;
    end else begin
      cmd.done          <= 1'b0;
      delay_line_move_0 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd.cmd_valid && cmd.cmd_ready) begin
            cmd.cmd_ready          <= 1'b0;
            delay_line_direction_0 <= cmd.cmd_dir;
            steps_q                <= cmd.cmd_steps;
            cmd.steps_done         <= '0;
            cmd.done_oor           <= 1'b0;
            if (cmd.cmd_op) begin
              state             <= S_LOAD;
              delay_line_load_0 <= 1'b1;
              cnt               <= CNT_W'(LOAD_CYCLES - 1);
            end else if (cmd.cmd_steps == '0 || clamp_now) begin
              state        <= S_DONE;
              cmd.done     <= 1'b1;
              cmd.done_oor <= cmd.cmd_steps != '0;
            end else begin
              state             <= S_MOVE;
              delay_line_move_0 <= 1'b1;
            end
          end else begin
            cmd.cmd_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          if (cnt == '0) begin
            state             <= S_DONE;
            delay_line_load_0 <= 1'b0;
            tap_pos           <= TAP_W'(TAP_RESET_VAL);
            cmd.done          <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_MOVE: begin
          state <= S_GAP;
          cnt   <= CNT_W'(GAP_CYCLES - 1);
        end
        S_GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (delay_line_out_of_range_0) begin
            state        <= S_DONE;
            cmd.done     <= 1'b1;
            cmd.done_oor <= 1'b1;
          end else begin
            cmd.steps_done <= steps_nxt;
            tap_pos        <= tap_nxt;
            if (steps_nxt == steps_q || clamp_nxt) begin
              state        <= S_DONE;
              cmd.done     <= 1'b1;
              cmd.done_oor <= steps_nxt != steps_q;
            end else begin
              state             <= S_MOVE;
              delay_line_move_0 <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state         <= S_IDLE;
          cmd.cmd_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iod_delay_line_step_ctrl.sv
// tb_iod_delay_line_step_ctrl: randomized commands scored against a step-by-step reference model via a completion queue
module tb_iod_delay_line_step_ctrl;
  localparam int G = 3, L = 2, TRV = 1, TMAX = 127;
`ifdef DLY_CTRL_TAP_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic mv, dr, ld, oor;
  logic [7:0] tap;
  iod_delay_line_step_ctrl_if #(.STEP_W(8)) cif ();
  iod_delay_line_step_ctrl #(
    .STEP_W(8), .TAP_W(8), .TAP_RESET_VAL(TRV), .TAP_MAX(TMAX), .GAP_CYCLES(G), .LOAD_CYCLES(L)
  ) dut (
    .fab_clk(clk), .sync_rst(rst), .cmd(cif.slave), .tap_pos(tap),
    .delay_line_move_0(mv), .delay_line_direction_0(dr), .delay_line_load_0(ld),
    .delay_line_out_of_range_0(oor)
  );
  typedef struct {int cyc; int steps; int oor; int tap; int moves; int loads;} exp_t;
  exp_t q[$];
  int cyc = 0, checks = 0, errs = 0, m_tap = TRV, n_mv = 0, n_ld = 0;
  logic exp_dir = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      n_mv = 0;
      n_ld = 0;
    end else begin
      if (mv) begin
        n_mv++;
        chk("move_dir", dr, exp_dir);
      end
      if (ld) n_ld++;
      if (cif.done) begin
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("steps_done", cif.steps_done, e.steps);
          chk("done_oor", cif.done_oor, e.oor);
          chk("tap_pos", tap, e.tap);
          chk("move_pulses", n_mv, e.moves);
          chk("load_cycles", n_ld, e.loads);
        end
        n_mv = 0;
        n_ld = 0;
      end
    end
  end
  // k: 1-based step whose last gap cycle sees OOR (0 = never); noise toggles OOR off that cycle and sends busy-time commands
  task automatic run(input bit op, input bit d, input int n, input int k, input bit noise);
    exp_t e;
    int lat, t, a, w, taken, pulses;
    bit o;
    if (op) begin
      lat = L + 1;
      e = '{0, 0, 0, TRV, 0, L};
    end else begin
      t = m_tap; taken = 0; pulses = 0; o = 0; lat = n * (1 + G) + 1;
      for (int i = 0; i < n; i++) begin
        if (CLAMP && (d ? t == TMAX : t == 0)) begin o = 1; lat = i * (1 + G) + 1; break; end
        pulses++;
        if (i + 1 == k) begin o = 1; lat = (i + 1) * (1 + G) + 1; break; end
        taken++;
        t = (t + (d ? 1 : -1)) & 255;
      end
      e = '{0, taken, int'(o), t, pulses, 0};
    end
    w = 0;
    @(negedge clk);
    while (!cif.cmd_ready && w < 200) begin @(negedge clk); w++; end
    chk("ready_wait", cif.cmd_ready, 1);
    if (!cif.cmd_ready) return;
    cif.cmd_valid = 1'b1; cif.cmd_op = op; cif.cmd_dir = d; cif.cmd_steps = 8'(n);
    @(posedge clk); #1;
    a = cyc; exp_dir = d; e.cyc = a + lat - 1;
    q.push_back(e);
    m_tap = e.tap;
    cif.cmd_valid = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      oor = (c == k * (1 + G)) || (noise && (c % (1 + G)) != 0 && $urandom_range(1) == 1);
      cif.cmd_valid = noise && c < lat && $urandom_range(1) == 1;
      cif.cmd_op = 1'($urandom_range(1)); cif.cmd_dir = 1'($urandom_range(1)); cif.cmd_steps = 8'($urandom_range(255));
    end
    @(negedge clk);
    oor = 1'b0; cif.cmd_valid = 1'b0;
    chk("pending_done", q.size(), 0);
    q.delete();
  endtask
  initial begin
    #2000000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    int n, k;
    cif.cmd_valid = 1'b0; cif.cmd_op = 1'b0; cif.cmd_dir = 1'b0; cif.cmd_steps = '0; oor = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", cif.cmd_ready, 0);
    chk("rst_tap", tap, TRV);
    chk("rst_move", mv, 0);
    chk("rst_load", ld, 0);
    chk("rst_dir", dr, 0);
    chk("rst_done", cif.done, 0);
    chk("rst_steps_done", cif.steps_done, 0);
    chk("rst_oor", cif.done_oor, 0);
    rst = 1'b0;
    run(0, 1, 4, 0, 0);
    run(1, 0, 0, 0, 0);
    run(0, 1, 10, 3, 0);
    run(0, 1, 0, 0, 0);
    run(1, 0, 0, 0, 0);
    run(0, 0, 5, 0, 0);
    run(1, 1, 0, 0, 1);
    // reset during the second step's gap: no completion, tap back to reset value
    @(negedge clk);
    while (!cif.cmd_ready) @(negedge clk);
    cif.cmd_valid = 1'b1; cif.cmd_op = 1'b0; cif.cmd_dir = 1'b1; cif.cmd_steps = 8'd10;
    @(posedge clk); #1;
    exp_dir = 1'b1; cif.cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_move", mv, 0);
    chk("midrst_load", ld, 0);
    chk("midrst_done", cif.done, 0);
    chk("midrst_tap", tap, TRV);
    chk("midrst_ready", cif.cmd_ready, 0);
    rst = 1'b0;
    m_tap = TRV;
    @(negedge clk);
    chk("postrst_ready", cif.cmd_ready, 1);
    run(0, 1, 2, 0, 1);
    for (int i = 0; i < 40; i++) begin
      n = ($urandom_range(7) == 0) ? 0 : $urandom_range(1, 6);
      k = ($urandom_range(2) == 0) ? $urandom_range(1, 6) : 0;
      run($urandom_range(4) == 0, 1'($urandom_range(1)), n, k, 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end
endmodule
